// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// Scans one digit per prescaler period with a single dead cycle between digits.
module seg7_scan_driver #(
    parameter int SCAN_BITS  = 17,
    parameter int BLINK_BITS = 25
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] HEXS,
    input  logic [3:0]  points,
    input  logic [3:0]  LES,
    input  logic [3:0]  BLINK,
    output logic [7:0]  SEG,
    output logic [3:0]  AN
);

    logic [SCAN_BITS-1:0]  r_presc;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    logic [1:0]            r_sel;

    logic       w_tick;
    logic       w_bph;
    logic       w_blanked;
    logic [3:0] w_digit;
    logic [6:0] w_dec;
    logic [7:0] w_seg_nxt;
    logic [3:0] w_an_nxt;

    assign w_tick    = &r_presc;
    assign w_bph     = r_blink_cnt[BLINK_BITS-1];
    assign w_digit   = HEXS[4*r_sel +: 4];
    assign w_blanked = LES[r_sel] | (BLINK[r_sel] & w_bph);

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
    always_comb begin
        w_dec = 7'h7F;
        case (w_digit)
            4'h0: w_dec = 7'h40;
            4'h1: w_dec = 7'h79;
            4'h2: w_dec = 7'h24;
            4'h3: w_dec = 7'h30;
            4'h4: w_dec = 7'h19;
            4'h5: w_dec = 7'h12;
            4'h6: w_dec = 7'h02;
            4'h7: w_dec = 7'h78;
            4'h8: w_dec = 7'h00;
            4'h9: w_dec = 7'h10;
            4'hA: w_dec = 7'h08;
            4'hB: w_dec = 7'h03;
            4'hC: w_dec = 7'h46;
            4'hD: w_dec = 7'h21;
            4'hE: w_dec = 7'h06;
            4'hF: w_dec = 7'h0E;
            default: w_dec = 7'h7F;
        endcase
    end

    // The dead cycle on tick keeps the old segment pattern from ghosting onto the next anode.
    always_comb begin
        w_seg_nxt = 8'hFF;
        w_an_nxt  = 4'hF;
        if (!w_tick && !w_blanked) begin
            w_seg_nxt = {~points[r_sel], w_dec};
            w_an_nxt  = ~(4'b0001 << r_sel);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_presc     <= '0;
            r_blink_cnt <= '0;
            r_sel       <= 2'd0;
            SEG         <= 8'hFF;
            AN          <= 4'hF;
        end else begin
            r_presc     <= r_presc + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (w_tick) begin
                r_sel <= r_sel + 2'd1;
            end
            SEG <= w_seg_nxt;
            AN  <= w_an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random inputs,
// compared against a model that derives slot/blink phase from the edge count since reset.
module tb_seg7_scan_driver;

    localparam int SB = 2;
    localparam int BB = 4;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] HEXS = 16'h0000;
    logic [3:0]  points = 4'h0;
    logic [3:0]  LES = 4'h0;
    logic [3:0]  BLINK = 4'h0;
    logic [7:0]  SEG;
    logic [3:0]  AN;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;   // rising edges since reset release

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.SCAN_BITS(SB), .BLINK_BITS(BB)) dut (
        .clk(clk), .RST(RST), .HEXS(HEXS), .points(points),
        .LES(LES), .BLINK(BLINK), .SEG(SEG), .AN(AN)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    // Edge j (0-based) lights slot j/period unless it is the last edge of the period.
    task automatic model(input int j, output logic [7:0] seg, output logic [3:0] an);
        int period, slot, nib;
        bit dead, bph;
        period = 1 << SB;
        slot   = (j / period) % 4;
        dead   = (j % period) == period - 1;
        bph    = ((j % (1 << BB)) >> (BB - 1)) & 1;
        nib    = (HEXS >> (4 * slot)) & 15;
        seg = 8'hFF;
        an  = 4'hF;
        if (!dead && !LES[slot] && !(BLINK[slot] && bph)) begin
            an  = 4'hF ^ (4'b0001 << slot);
            seg = {~points[slot], dec_tab[nib]};
        end
    endtask

    task automatic step(input string tag);
        logic [7:0] es;
        logic [3:0] ea;
        @(posedge clk);
        model(k, es, ea);
        #1;
        check({tag, "_seg"}, SEG, es);
        check({tag, "_an"}, AN, ea);
        k++;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check("rst_seg", SEG, 8'hFF);
        check("rst_an", AN, 4'hF);
        HEXS = 16'h1234; points = 4'b0100;
        @(negedge clk); RST = 1'b0; k = 0;

        // Basic frame, with explicit values for the first digit
        step("t1");
        check("t1_first_seg", SEG, 8'h99);
        check("t1_first_an", AN, 4'hE);
        repeat (31) step("t1");

        // Sweep digit 0 over all values, one value per frame
        points = 4'h0;
        while (k % 16 != 0) step("t2_align");
        for (int v = 0; v < 16; v++) begin
            HEXS[3:0] = v[3:0];
            repeat (16) step("t2");
        end

        // Blank digit 3
        HEXS = 16'h1234; LES = 4'b1000;
        repeat (32) step("t3");
        LES = 4'h0;

        // Blink masks
        BLINK = 4'b0001;
        repeat (32) step("t4a");
        BLINK = 4'b1100;
        repeat (32) step("t4b");
        BLINK = 4'h0;

        // Reset pulse mid digit 2
        while (k % 16 != 9) step("t5_align");
        #2 RST = 1'b1;
        #1;
        check("t5_async_seg", SEG, 8'hFF);
        check("t5_async_an", AN, 4'hF);
        RST = 1'b0; k = 0;
        step("t5");
        check("t5_restart_an", AN, 4'hE);
        repeat (15) step("t5");

        // Mid-digit data change
        step("t6");
        HEXS = 16'h5678;
        step("t6");
        check("t6_an", AN, 4'hE);
        repeat (14) step("t6");

        // Random inputs
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) HEXS = 16'($urandom);
            if ($urandom_range(0, 7) == 0) points = 4'($urandom);
            if ($urandom_range(0, 15) == 0) LES = 4'($urandom);
            if ($urandom_range(0, 15) == 0) BLINK = 4'($urandom);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
